serial_mod_n: RTL and testbench

Bit-serial modulo-N remainder engine: consumes an MSB-first bit stream one bit per beat and tracks the running remainder modulo a divisor chosen per frame. It succeeds the fixed divide-by-3 state machine. The divisor width and maximum frame length are parameters, and the block adds a start/last framing handshake, a per-frame bit count and error flagging. It sits behind a serial deserialiser front-end and produces divisibility flags for downstream checking logic.

---
 rtl/serial_mod_n_if.sv | 30 +++
 rtl/serial_mod_n.sv | 92 +++++++++
 tb/tb_serial_mod_n.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_mod_n_if.sv
// Bus bundle for the bit-serial modulo-N engine.
// The master side drives the frame controls and the bit stream. The slave side returns the remainder and status.
interface serial_mod_n_if #(
    parameter int DW       = 8,
    parameter int MAX_BITS = 64
);
    localparam int CW = $clog2(MAX_BITS + 1);

    logic          i_start;
    logic [DW-1:0] i_divisor;
    logic          i_valid;
    logic          i_bit;
    logic          i_last;
    logic [DW-1:0] o_rem;
    logic          o_divisible;
    logic [CW-1:0] o_nbits;
    logic          o_busy;
    logic          o_done;
    logic          o_err;

    modport master (
        output i_start, i_divisor, i_valid, i_bit, i_last,
        input  o_rem, o_divisible, o_nbits, o_busy, o_done, o_err
    );

    modport slave (
        input  i_start, i_divisor, i_valid, i_bit, i_last,
        output o_rem, o_divisible, o_nbits, o_busy, o_done, o_err
    );
endinterface

// File: rtl/serial_mod_n.sv
// Bit-serial MSB-first remainder engine: tracks the stream value modulo a per-frame divisor.
// Provides start/last framing, a saturating beat count and a sticky per-frame error flag.
module serial_mod_n #(
    parameter int DW       = 8,
    parameter int MAX_BITS = 64
) (
    input logic            i_clk,
    input logic            i_rst,
    serial_mod_n_if.slave  bus
);
    localparam int CW = $clog2(MAX_BITS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_n;
    logic [DW-1:0] d, d_n;
    logic [DW-1:0] rem, rem_n, base_rem;
    logic [CW-1:0] nbits, nbits_n, base_nbits;
    logic          err, err_n, base_err;
    logic          divisible;
    logic          accept;
    logic [DW:0]   t;

    // A start wins over everything else and rebases the frame, so the beat on the start cycle builds on rem = 0.
    always_comb begin
        state_n    = state;
        d_n        = d;
        base_rem   = rem;
        base_nbits = nbits;
        base_err   = err;
        accept     = 1'b0;

        if (bus.i_start) begin
            d_n        = bus.i_divisor;
            base_rem   = '0;
            base_nbits = '0;
            base_err   = (bus.i_divisor == '0);
            accept     = bus.i_valid;
            state_n    = (state == IDLE && bus.i_valid && bus.i_last) ? DONE : RUN;
        end else begin
            case (state)
                IDLE: state_n = IDLE;
                RUN: begin
                    accept = bus.i_valid;
                    if (bus.i_valid && bus.i_last)
                        state_n = DONE;
                end
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end

        t       = {base_rem, bus.i_bit};
        rem_n   = base_rem;
        nbits_n = base_nbits;
        err_n   = base_err;

        // Since rem < d, a single subtraction is enough. If d = 0, the value simply wraps to DW bits.
        if (accept) begin
            rem_n = (t >= {1'b0, d_n}) ? DW'(t - {1'b0, d_n}) : t[DW-1:0];
            if (base_nbits == CW'(MAX_BITS))
                err_n = 1'b1;
            else
                nbits_n = base_nbits + CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            d         <= '0;
            rem       <= '0;
            nbits     <= '0;
            err       <= 1'b0;
            divisible <= 1'b1;
        end else begin
            state     <= state_n;
            d         <= d_n;
            rem       <= rem_n;
            nbits     <= nbits_n;
            err       <= err_n;
            divisible <= (rem_n == '0) && !err_n;
        end
    end

    assign bus.o_rem       = rem;
    assign bus.o_nbits     = nbits;
    assign bus.o_err       = err;
    assign bus.o_divisible = divisible;
    assign bus.o_busy      = (state == RUN);
    assign bus.o_done      = (state == DONE);
endmodule

// File: tb/tb_serial_mod_n.sv
// Bench for serial_mod_n: two instances (MAX_BITS 64 and 4) share one stimulus stream.
// A value-level model predicts both, with literal checks at key points.
module tb_serial_mod_n;
    localparam int DW   = 8;
    localparam int MAXA = 64;
    localparam int MAXB = 4;

    logic i_clk = 1'b0;
    logic i_rst;
    int   checks = 0;
    int   errors = 0;

    always #5 i_clk = ~i_clk;

    serial_mod_n_if #(.DW(DW), .MAX_BITS(MAXA)) bus_a ();
    serial_mod_n_if #(.DW(DW), .MAX_BITS(MAXB)) bus_b ();

    serial_mod_n #(.DW(DW), .MAX_BITS(MAXA)) dut_a (.i_clk(i_clk), .i_rst(i_rst), .bus(bus_a.slave));
    serial_mod_n #(.DW(DW), .MAX_BITS(MAXB)) dut_b (.i_clk(i_clk), .i_rst(i_rst), .bus(bus_b.slave));

    // The model keeps the whole frame value as a number; each remainder is that value mod d.
    bit              m_valid  = 1'b0;
    bit              m_framed = 1'b0;
    bit              m_run    = 1'b0;
    bit              m_done   = 1'b0;
    logic [DW-1:0]   m_d      = '0;
    longint unsigned m_val    = 0;
    int              m_cnt    = 0;

    function automatic logic [DW-1:0] exp_rem();
        longint unsigned dl;
        logic [63:0]     r;
        if (!m_framed) return '0;
        if (m_d == '0) return m_val[DW-1:0];
        dl = longint'(m_d);
        r  = m_val % dl;
        return r[DW-1:0];
    endfunction

    function automatic int exp_nbits(input int mx);
        return (m_cnt > mx) ? mx : m_cnt;
    endfunction

    function automatic bit exp_err(input int mx);
        return m_framed && ((m_d == '0) || (m_cnt > mx));
    endfunction

    function automatic bit exp_div(input int mx);
        return (exp_rem() == '0) && !exp_err(mx);
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_step();
        bit was_run, was_done, acc;
        m_valid  = 1'b1;
        if (i_rst) begin
            m_framed = 1'b0; m_d = '0; m_val = 0; m_cnt = 0; m_run = 1'b0; m_done = 1'b0;
        end else begin
            was_run  = m_run;
            was_done = m_done;
            acc      = 1'b0;
            m_done   = 1'b0;
            if (bus_a.i_start) begin
                m_framed = 1'b1;
                m_d      = bus_a.i_divisor;
                m_val    = 0;
                m_cnt    = 0;
                acc      = bus_a.i_valid;
                m_run    = !(!was_run && !was_done && bus_a.i_valid && bus_a.i_last);
                m_done   = !m_run;
            end else if (was_run) begin
                acc = bus_a.i_valid;
                if (bus_a.i_valid && bus_a.i_last) begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                end
            end else begin
                m_run = 1'b0;
            end
            if (acc) begin
                m_val = (m_val << 1) | longint'(bus_a.i_bit);
                m_cnt++;
            end
        end
    endtask

    // Inputs change just after a rising edge. Outputs are compared with the model on the falling edge.
    always @(negedge i_clk) begin
        if (m_valid) begin
            check_output("a_rem",  bus_a.o_rem,       exp_rem());
            check_output("a_nbit", bus_a.o_nbits,     exp_nbits(MAXA));
            check_output("a_err",  bus_a.o_err,       exp_err(MAXA));
            check_output("a_div",  bus_a.o_divisible, exp_div(MAXA));
            check_output("a_busy", bus_a.o_busy,      m_run);
            check_output("a_done", bus_a.o_done,      m_done);
            check_output("b_rem",  bus_b.o_rem,       exp_rem());
            check_output("b_nbit", bus_b.o_nbits,     exp_nbits(MAXB));
            check_output("b_err",  bus_b.o_err,       exp_err(MAXB));
            check_output("b_div",  bus_b.o_divisible, exp_div(MAXB));
            check_output("b_busy", bus_b.o_busy,      m_run);
            check_output("b_done", bus_b.o_done,      m_done);
        end
    end

    task automatic apply_stimulus(input bit rst, input bit st, input logic [DW-1:0] dv,
                                  input bit v, input bit b, input bit l);
        i_rst = rst;
        bus_a.i_start = st; bus_a.i_divisor = dv; bus_a.i_valid = v; bus_a.i_bit = b; bus_a.i_last = l;
        bus_b.i_start = st; bus_b.i_divisor = dv; bus_b.i_valid = v; bus_b.i_bit = b; bus_b.i_last = l;
        @(posedge i_clk);
        #1;
        model_step();
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic beat(input bit b, input bit l);
        apply_stimulus(1'b0, 1'b0, '0, 1'b1, b, l);
    endtask

    task automatic start(input logic [DW-1:0] dv, input bit v, input bit b, input bit l);
        apply_stimulus(1'b0, 1'b1, dv, v, b, l);
    endtask

    initial begin
        int unsigned     dv, n;
        longint unsigned val;
        bit              b;
        logic [63:0]     r;

        apply_stimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_output("rst_rem", bus_a.o_rem, 0);
        check_output("rst_div", bus_a.o_divisible, 1);
        check_output("rst_nbits", bus_a.o_nbits, 0);
        check_output("rst_busy", bus_a.o_busy, 0);
        idle();

        // d=3, value 6 (bits 1,1,0)
        start(8'd3, 1'b1, 1'b1, 1'b0);
        check_output("t1_rem0", bus_a.o_rem, 1);
        check_output("t1_busy", bus_a.o_busy, 1);
        beat(1'b1, 1'b0);
        check_output("t1_rem1", bus_a.o_rem, 0);
        beat(1'b0, 1'b1);
        check_output("t1_rem2", bus_a.o_rem, 0);
        check_output("t1_done", bus_a.o_done, 1);
        check_output("t1_nbits", bus_a.o_nbits, 3);
        check_output("t1_div", bus_a.o_divisible, 1);
        idle();
        check_output("t1_donelow", bus_a.o_done, 0);

        // d=3, value 7; then d=5, value 27, started on the DONE cycle
        start(8'd3, 1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b1);
        check_output("t2_rem", bus_a.o_rem, 1);
        check_output("t2_div", bus_a.o_divisible, 0);
        check_output("t2_done", bus_a.o_done, 1);
        start(8'd5, 1'b1, 1'b1, 1'b0);
        check_output("t2b_rem0", bus_a.o_rem, 1);
        check_output("t2b_busy", bus_a.o_busy, 1);
        beat(1'b1, 1'b0);
        check_output("t2b_rem1", bus_a.o_rem, 3);
        beat(1'b0, 1'b0);
        check_output("t2b_rem2", bus_a.o_rem, 1);
        beat(1'b1, 1'b0);
        check_output("t2b_rem3", bus_a.o_rem, 3);
        beat(1'b1, 1'b1);
        check_output("t2b_rem4", bus_a.o_rem, 2);
        check_output("t2b_done", bus_a.o_done, 1);
        idle();

        // d=0 frame: error from the first cycle, remainder wraps (value 11)
        start(8'd0, 1'b0, 1'b0, 1'b0);
        check_output("t3_err", bus_a.o_err, 1);
        check_output("t3_div", bus_a.o_divisible, 0);
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b1);
        check_output("t3_done", bus_a.o_done, 1);
        check_output("t3_rem", bus_a.o_rem, 11);
        idle();
        check_output("t3_hold_err", bus_a.o_err, 1);
        start(8'd3, 1'b1, 1'b1, 1'b1);
        check_output("t3b_err", bus_a.o_err, 0);
        check_output("t3b_done", bus_a.o_done, 1);
        check_output("t3b_rem", bus_a.o_rem, 1);
        check_output("t3b_busy", bus_a.o_busy, 0);
        idle();

        // Divisor 1
        start(8'd1, 1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b1);
        check_output("d1_rem", bus_a.o_rem, 0);
        check_output("d1_div", bus_a.o_divisible, 1);
        idle();

        // Six beats, d=7, value 45: instance b saturates at 4 beats
        start(8'd7, 1'b1, 1'b1, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b0);
        check_output("t4_b_nbits4", bus_b.o_nbits, 4);
        check_output("t4_b_err4", bus_b.o_err, 0);
        beat(1'b0, 1'b0);
        check_output("t4_b_err5", bus_b.o_err, 1);
        check_output("t4_b_nbits5", bus_b.o_nbits, 4);
        beat(1'b1, 1'b1);
        check_output("t4_b_rem", bus_b.o_rem, 3);
        check_output("t4_a_nbits", bus_a.o_nbits, 6);
        check_output("t4_a_err", bus_a.o_err, 0);
        idle();

        // Restart mid-frame with i_last on the restart beat
        start(8'd5, 1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        start(8'd3, 1'b1, 1'b1, 1'b1);
        check_output("t5_done", bus_a.o_done, 0);
        check_output("t5_nbits", bus_a.o_nbits, 1);
        check_output("t5_busy", bus_a.o_busy, 1);
        idle();
        check_output("t5_nodone", bus_a.o_done, 0);
        beat(1'b0, 1'b1);
        check_output("t5_rem", bus_a.o_rem, 2);
        check_output("t5_done2", bus_a.o_done, 1);
        idle();

        // Reset mid-frame; beats without start are then ignored
        start(8'd9, 1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        check_output("t6_rem", bus_a.o_rem, 0);
        check_output("t6_busy", bus_a.o_busy, 0);
        check_output("t6_div", bus_a.o_divisible, 1);
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b1);
        check_output("t6_nbits", bus_a.o_nbits, 0);
        check_output("t6_idle_done", bus_a.o_done, 0);

        // Random frames with gaps in the valid beats
        for (int f = 0; f < 40; f++) begin
            dv  = $urandom_range(1, 255);
            n   = $urandom_range(1, 40);
            b   = 1'($urandom_range(0, 1));
            val = longint'(b);
            start(DW'(dv), 1'b1, b, (n == 1));
            for (int k = 1; k < int'(n); k++) begin
                if ($urandom_range(0, 3) == 0) idle();
                b   = 1'($urandom_range(0, 1));
                val = (val << 1) | longint'(b);
                beat(b, (k == int'(n) - 1));
            end
            r = val % longint'(dv);
            check_output("rnd_rem", bus_a.o_rem, r);
            check_output("rnd_done", bus_a.o_done, 1);
            idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
